// File: rtl/memwrport_pkg.sv
// rtl/memwrport_pkg.sv - FSM state codes, burst/row constants and helpers for memwrport
package memwrport_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int BURST_WORDS = 4;
  localparam int ROW_WORDS   = 256;

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/memwrport_wrfifo.sv
// rtl/memwrport_wrfifo.sv - wrfifo: synchronous show-ahead write FIFO with occupancy count
module wrfifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push while full is dropped; a pop while empty is ignored.
  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memwrport.sv
// rtl/memwrport.sv - pixel write port packing FIFO words into row-safe memory bursts
// MEMWRPORT_STATS_EN adds saturating nbursts/ndropped counter outputs.
module memwrport
  import memwrport_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BURST = BURST_WORDS
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [22:0] base,
  input  logic        sof,
  input  logic        flush,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [22:0] memaddr,
  output logic [31:0] memwdata,
  output logic [1:0]  memlen,
  output logic        memwr,
  output logic        memreq,
  input  logic        memack,
  output logic        flushdone
`ifdef MEMWRPORT_STATS_EN
  ,
  output logic [15:0] nbursts,
  output logic [15:0] ndropped
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t      state, state_nx;
  logic [CW-1:0] count;
  logic [31:0] head;
  logic [22:0] addr;
  logic [22:0] base_lat;
  logic [1:0]  beat;
  logic        sof_pend;
  logic        flush_pend;
  logic        fp;
  logic        idle_empty;
  logic        start;
  logic        push;
  logic        pop;
  logic        last_ack;
  logic [31:0] blen;

  wrfifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .dout  (head),
    .count (count)
  );

  assign wready     = (count != CW'(DEPTH));
  assign push       = wvalid && wready;
  assign pop        = (state == ST_BURST) && memack;
  assign last_ack   = pop && (beat == memlen);
  assign fp         = flush_pend || flush;
  assign idle_empty = (state == ST_IDLE) && (count == '0);
  assign start      = (state == ST_IDLE) &&
                      ((count >= CW'(BURST)) || (fp && (count != '0)));
  // Burst length is clipped so the column counter never wraps inside one request.
  assign blen       = min3(32'(BURST), 32'(count), 32'(ROW_WORDS) - 32'(addr[7:0]));

  assign memreq   = (state == ST_BURST);
  assign memwr    = 1'b1;
  assign memwdata = (state == ST_BURST) ? head : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)    state_nx = ST_BURST;
      ST_BURST: if (last_ack) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr       <= '0;
      base_lat   <= '0;
      memaddr    <= '0;
      memlen     <= '0;
      beat       <= '0;
      sof_pend   <= 1'b0;
      flush_pend <= 1'b0;
      flushdone  <= 1'b0;
    end else begin
      if (start) begin
        memaddr <= addr;
        memlen  <= 2'(blen - 32'd1);
        beat    <= '0;
      end
      if (pop) begin
        addr <= addr + 23'd1;
        beat <= beat + 2'd1;
      end
      // A newer sof replaces the pending base until it can be applied.
      if ((sof || sof_pend) && idle_empty) begin
        addr     <= sof ? base : base_lat;
        sof_pend <= 1'b0;
      end else if (sof) begin
        sof_pend <= 1'b1;
        base_lat <= base;
      end
      flushdone <= fp && idle_empty;
      if (fp && idle_empty) flush_pend <= 1'b0;
      else if (flush)       flush_pend <= 1'b1;
    end
  end

`ifdef MEMWRPORT_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nbursts  <= '0;
      ndropped <= '0;
    end else begin
      if (last_ack && (nbursts != 16'hFFFF))              nbursts  <= nbursts + 16'd1;
      if (wvalid && !wready && (ndropped != 16'hFFFF))    ndropped <= ndropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memwrport.sv
// tb/tb_memwrport.sv - directed self-checking bench for memwrport
module tb_memwrport;

  logic        clk = 1'b0;
  logic        rstn;
  logic [22:0] base;
  logic        sof;
  logic        flush;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [22:0] memaddr;
  logic [31:0] memwdata;
  logic [1:0]  memlen;
  logic        memwr;
  logic        memreq;
  logic        memack;
  logic        flushdone;
`ifdef MEMWRPORT_STATS_EN
  logic [15:0] nbursts;
  logic [15:0] ndropped;
`endif

  int checks = 0;
  int errors = 0;

  memwrport #(.DEPTH(16), .BURST(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .base      (base),
    .sof       (sof),
    .flush     (flush),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .memaddr   (memaddr),
    .memwdata  (memwdata),
    .memlen    (memlen),
    .memwr     (memwr),
    .memreq    (memreq),
    .memack    (memack),
    .flushdone (flushdone)
`ifdef MEMWRPORT_STATS_EN
    ,
    .nbursts   (nbursts),
    .ndropped  (ndropped)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] d0);
    for (int i = 0; i < n; i++) begin
      wdata  = d0 + 32'(i);
      wvalid = 1'b1;
      tick();
    end
    wvalid = 1'b0;
  endtask

  task automatic do_sof(input logic [22:0] b);
    base = b;
    sof  = 1'b1;
    tick();
    sof  = 1'b0;
  endtask

  task automatic do_burst(input logic [22:0] a, input logic [1:0] len, input logic [31:0] d0);
    int n;
    n = 0;
    while (!memreq && n < 40) begin
      tick();
      n++;
    end
    check("memreq_up", 32'(memreq), 32'd1);
    check("memaddr", 32'(memaddr), 32'(a));
    check("memlen", 32'(memlen), 32'(len));
    check("memwr", 32'(memwr), 32'd1);
    memack = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      check("memwdata", memwdata, d0 + 32'(i));
      tick();
    end
    memack = 1'b0;
    check("memreq_down", 32'(memreq), 32'd0);
  endtask

  task automatic wait_flushdone();
    int n;
    n = 0;
    while (!flushdone && n < 20) begin
      tick();
      n++;
    end
    check("flushdone_pulse", 32'(flushdone), 32'd1);
    tick();
    check("flushdone_clear", 32'(flushdone), 32'd0);
  endtask

  initial begin
    rstn   = 1'b0;
    base   = '0;
    sof    = 1'b0;
    flush  = 1'b0;
    wdata  = '0;
    wvalid = 1'b0;
    memack = 1'b0;
    tick();
    tick();
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_memreq", 32'(memreq), 32'd0);
    check("rst_memaddr", 32'(memaddr), 32'd0);
    check("rst_memlen", 32'(memlen), 32'd0);
    check("rst_memwdata", memwdata, 32'd0);
    check("rst_flushdone", 32'(flushdone), 32'd0);
    rstn = 1'b1;
    tick();

    // two full bursts from base 0x100
    do_sof(23'h000100);
    push_n(8, 32'hA000_0000);
    do_burst(23'h000100, 2'd3, 32'hA000_0000);
    do_burst(23'h000104, 2'd3, 32'hA000_0004);

    // row boundary split at 0xFE, drained by flush
    do_sof(23'h0000FE);
    push_n(4, 32'hB000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_burst(23'h0000FE, 2'd1, 32'hB000_0000);
    do_burst(23'h000100, 2'd1, 32'hB000_0002);
    wait_flushdone();

    // partial burst of 3 on flush; flushdone exactly one cycle after the last ack
    do_sof(23'h000200);
    push_n(3, 32'hC000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_burst(23'h000200, 2'd2, 32'hC000_0000);
    check("flush3_not_yet", 32'(flushdone), 32'd0);
    tick();
    check("flush3_done", 32'(flushdone), 32'd1);
    tick();
    check("flush3_clear", 32'(flushdone), 32'd0);

    // flush with empty FIFO completes in one cycle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty", 32'(flushdone), 32'd1);
    tick();
    check("flush_empty_clr", 32'(flushdone), 32'd0);

    // fill to full with memack low; 17th push dropped
    do_sof(23'h000300);
    push_n(16, 32'hD000_0000);
    check("full_wready", 32'(wready), 32'd0);
    push_n(1, 32'hDEAD_BEEF);
    check("full_wready2", 32'(wready), 32'd0);
`ifdef MEMWRPORT_STATS_EN
    check("ndropped", 32'(ndropped), 32'd1);
`endif
    for (int b = 0; b < 4; b++)
      do_burst(23'h000300 + 23'(4 * b), 2'd3, 32'hD000_0000 + 32'(4 * b));
    check("drain_wready", 32'(wready), 32'd1);
`ifdef MEMWRPORT_STATS_EN
    check("nbursts", 32'(nbursts), 32'd9);
`endif

    // sof during a burst: current burst keeps old address, latest base applied after drain
    do_sof(23'h000310);
    push_n(4, 32'hE000_0000);
    tick();
    check("mid_memreq", 32'(memreq), 32'd1);
    do_sof(23'h123456);
    do_sof(23'h400000);
    do_burst(23'h000310, 2'd3, 32'hE000_0000);
    push_n(4, 32'hE100_0000);
    do_burst(23'h400000, 2'd3, 32'hE100_0000);

    // reset after 2 of 4 acks
    push_n(4, 32'hF000_0000);
    tick();
    check("rst_mid_req", 32'(memreq), 32'd1);
    check("rst_mid_addr", 32'(memaddr), 32'h400004);
    memack = 1'b1;
    tick();
    tick();
    memack = 1'b0;
    rstn = 1'b0;
    tick();
    check("rst_mid_memreq", 32'(memreq), 32'd0);
    check("rst_mid_memaddr", 32'(memaddr), 32'd0);
    check("rst_mid_wready", 32'(wready), 32'd1);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rst_mid_quiet", 32'(memreq), 32'd0);
    push_n(4, 32'hF100_0000);
    do_burst(23'h000000, 2'd3, 32'hF100_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
